// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: drives an SRAM-like req/addr_ok/data_ok
// bus, stalls the pipeline while an access is pending and aligns/extends load data.
module mem_access_unit #(
  parameter int EXC_W    = 32,
  parameter int ADEL_BIT = 4,
  parameter int ADES_BIT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall_i,
  input  logic             mem_read_flag_i,
  input  logic             mem_write_flag_i,
  input  logic             mem_sign_ext_flag_i,
  input  logic [3:0]       mem_sel_i,
  input  logic [31:0]      mem_write_data_i,
  input  logic [31:0]      result_i,
  input  logic [EXC_W-1:0] exception_type_i,
  output logic             ram_req_o,
  output logic             ram_wr_o,
  output logic [3:0]       ram_wstrb_o,
  output logic [31:0]      ram_addr_o,
  output logic [31:0]      ram_wdata_o,
  input  logic             ram_addr_ok_i,
  input  logic             ram_data_ok_i,
  input  logic [31:0]      ram_rdata_i,
  output logic             stall_request_o,
  output logic [31:0]      result_o,
  output logic [31:0]      bad_vaddr_o,
  output logic [EXC_W-1:0] exception_type_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        drain_req_q, drain_req_d;
  logic [31:0] rdata_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        wr_q;

  logic        is_byte, is_half, is_word, sel_legal;
  logic [1:0]  lane;
  logic        mem_op, addr_err, access;
  logic [31:0] addr_live, wdata_live;
  logic [3:0]  wstrb_live;
  logic        load_en, latch_en, bypass_valid;

  function automatic logic [31:0] align_load(input logic [31:0] d, input logic [1:0] ln,
                                             input logic b_sz, input logic h_sz,
                                             input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{ln, 3'b000} +: 8];
    h = d[{ln[1], 4'b0000} +: 16];
    if (b_sz)      return {{24{sext & b[7]}}, b};
    else if (h_sz) return {{16{sext & h[15]}}, h};
    else           return d;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin : sel_decode
    is_byte = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    lane    = 2'd0;
    case (mem_sel_i)
      4'b0001: is_byte = 1'b1;
      4'b0010: begin is_byte = 1'b1; lane = 2'd1; end
      4'b0100: begin is_byte = 1'b1; lane = 2'd2; end
      4'b1000: begin is_byte = 1'b1; lane = 2'd3; end
      4'b0011: is_half = 1'b1;
      4'b1100: begin is_half = 1'b1; lane = 2'd2; end
      4'b1111: is_word = 1'b1;
      default: ;
    endcase
  end

  assign sel_legal = is_byte | is_half | is_word;
  assign mem_op    = mem_read_flag_i | mem_write_flag_i;
  assign addr_err  = mem_op & ~sel_legal;
  assign access    = mem_op & ~addr_err & (exception_type_i == '0) & ~flush;

  assign addr_live  = {result_i[31:2], 2'b00};
  assign wstrb_live = mem_write_flag_i ? mem_sel_i : 4'b0000;
  assign wdata_live = is_byte ? {4{mem_write_data_i[7:0]}} :
                      is_half ? {2{mem_write_data_i[15:0]}} : mem_write_data_i;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin : state_reg
    if (!rst) begin
      state_q     <= S_IDLE;
      drain_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_req_q <= drain_req_d;
    end
  end

  // A request raised in IDLE is accepted like one in REQ so it is never issued twice.
  always_comb begin : next_state
    state_d     = state_q;
    drain_req_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (ram_addr_ok_i && ram_data_ok_i) state_d = S_DONE;
          else if (ram_addr_ok_i)             state_d = S_WAIT;
          else                                state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ram_addr_ok_i) begin
          if (ram_data_ok_i) state_d = flush ? S_IDLE : S_DONE;
          else               state_d = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_d     = S_DRAIN;
          drain_req_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (ram_data_ok_i) state_d = flush ? S_IDLE : S_DONE;
        else if (flush)    state_d = S_DRAIN;
      end
      S_DONE: begin
        if (flush || !stall_i) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (drain_req_q && !ram_addr_ok_i) drain_req_d = 1'b1;
        else if (ram_data_ok_i)            state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign load_en  = (state_d == S_DONE) && (state_q != S_DONE);
  assign latch_en = (state_q == S_IDLE) && access;

  // Bus fields are captured at issue so a request outstanding across a flush stays stable.
  always_ff @(posedge clk or negedge rst) begin : data_reg
    if (!rst) begin
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      if (load_en) rdata_q <= ram_rdata_i;
      if (latch_en) begin
        addr_q  <= addr_live;
        wdata_q <= wdata_live;
        wstrb_q <= wstrb_live;
        wr_q    <= mem_write_flag_i;
      end
    end
  end

  assign bypass_valid = ram_data_ok_i &
                        ((state_q == S_REQ) | (state_q == S_WAIT) |
                         ((state_q == S_IDLE) & access & ram_addr_ok_i));

  always_comb begin : outputs
    ram_req_o       = 1'b0;
    stall_request_o = 1'b0;
    case (state_q)
      S_IDLE:  begin ram_req_o = access;      stall_request_o = access; end
      S_REQ:   begin ram_req_o = 1'b1;        stall_request_o = 1'b1;   end
      S_WAIT:  stall_request_o = 1'b1;
      S_DRAIN: begin ram_req_o = drain_req_q; stall_request_o = mem_op; end
      default: ;
    endcase
    ram_req_o       = ram_req_o & rst;
    stall_request_o = stall_request_o & rst;

    if (state_q == S_IDLE) begin
      ram_addr_o  = addr_live;
      ram_wdata_o = wdata_live;
      ram_wstrb_o = wstrb_live;
      ram_wr_o    = mem_write_flag_i;
    end else begin
      ram_addr_o  = addr_q;
      ram_wdata_o = wdata_q;
      ram_wstrb_o = wstrb_q;
      ram_wr_o    = wr_q;
    end

    if (state_q == S_DONE)
      result_o = align_load(rdata_q, lane, is_byte, is_half, mem_sign_ext_flag_i);
    else if (bypass_valid)
      result_o = align_load(ram_rdata_i, lane, is_byte, is_half, mem_sign_ext_flag_i);
    else
      result_o = result_i;

    bad_vaddr_o                = addr_err ? result_i : 32'h0;
    exception_type_o           = exception_type_i;
    exception_type_o[ADEL_BIT] = exception_type_i[ADEL_BIT] | (addr_err & mem_read_flag_i);
    exception_type_o[ADES_BIT] = exception_type_i[ADES_BIT] | (addr_err & mem_write_flag_i);
  end

endmodule
